// File: rtl/echo_pkg.sv
// echo_pkg: shared widths, tap reset defaults and FSM state type for the echo tap generator.
package echo_pkg;
   localparam int DATA_W_DEF = 16;
   localparam int COEF_W_DEF = 16;
   localparam logic signed [15:0] DEF_COEF0 = 16'sh4000;
   localparam logic signed [15:0] DEF_COEF1 = 16'sh2666;
   localparam logic signed [15:0] DEF_COEF2 = 16'sh1999;
   typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;
   function automatic int acc_width(input int data_w, input int coef_w, input int ntaps);
      return data_w + coef_w + $clog2(ntaps);
   endfunction
   function automatic int def_delay(input int k);
      return k < 3 ? k : 0;
   endfunction
   function automatic logic signed [15:0] def_coef(input int k);
      return k == 0 ? DEF_COEF0 : k == 1 ? DEF_COEF1 : k == 2 ? DEF_COEF2 : 16'sh0000;
   endfunction
endpackage

// File: rtl/echo_sat_round.sv
// echo_sat_round: rounds a Q-scaled accumulator to DATA_W with half-up rounding and saturation.
module echo_sat_round #(
   parameter int ACC_W = 34,
   parameter int DATA_W = 16,
   parameter int COEF_W = 16
) (
   input  logic signed [ACC_W-1:0]  acc,
   output logic signed [DATA_W-1:0] q
);
   localparam int SW = ACC_W + 1;
   localparam logic [SW-1:0] HALF = SW'(1) << (COEF_W - 2);
   localparam logic signed [SW-1:0] MAXV = {{(SW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [SW-1:0] MINV = {{(SW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
   logic signed [SW-1:0] sum;
   logic signed [SW-1:0] shr;
   // one guard bit keeps the rounding add from wrapping
   assign sum = {acc[ACC_W-1], acc} + HALF;
   assign shr = sum >>> (COEF_W - 1);
   always_comb q = shr > MAXV ? MAXV[DATA_W-1:0] : shr < MINV ? MINV[DATA_W-1:0] : shr[DATA_W-1:0];
endmodule

// File: rtl/echo_tap_generator.sv
// echo_tap_generator: multi-tap weighted echo of an input stream over a circular delay line,
// with programmable per-tap delay/coefficient, one multiply-accumulate per cycle.
module echo_tap_generator
   import echo_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int COEF_W = COEF_W_DEF,
   parameter int NTAPS = 4,
   parameter int DEPTH = 64,
   localparam int ADDR_W = $clog2(DEPTH),
   localparam int TAP_W = $clog2(NTAPS)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] in_data,
   input  logic                     bypass,
   output logic                     out_valid,
   output logic signed [DATA_W-1:0] out_data,
   input  logic                     cfg_we,
   input  logic [TAP_W-1:0]         cfg_tap,
   input  logic [ADDR_W-1:0]        cfg_delay,
   input  logic signed [COEF_W-1:0] cfg_coef,
   output logic                     cfg_ready
);
   localparam int ACC_W = acc_width(DATA_W, COEF_W, NTAPS);
   localparam int PW = DATA_W + COEF_W;
   state_t state, state_nx;
   logic signed [DATA_W-1:0] line [DEPTH];
   logic [ADDR_W-1:0] tap_delay [NTAPS];
   logic signed [COEF_W-1:0] tap_coef [NTAPS];
   logic [ADDR_W-1:0] wr_ptr, base, rd_addr;
   logic [TAP_W-1:0] k;
   logic signed [ACC_W-1:0] acc;
   logic signed [PW-1:0] prod;
   logic signed [DATA_W-1:0] samp, out_hold, sat_q, out_val;
   logic byp, accept, last_tap;

   assign accept = state == IDLE && in_valid;
   assign last_tap = k == TAP_W'(NTAPS - 1);
   assign rd_addr = base - tap_delay[k];
   assign prod = PW'(tap_coef[k]) * PW'(line[rd_addr]);
   assign out_val = byp ? samp : sat_q;

   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= state_nx;

   always_comb
      state_nx = state == IDLE ? (in_valid ? ACCUM : IDLE) :
                 state == ACCUM ? (last_tap ? OUT : ACCUM) : IDLE;

   always_comb begin
      in_ready = state == IDLE;
      cfg_ready = state == IDLE;
      out_valid = state == OUT;
      out_data = state == OUT ? out_val : out_hold;
   end

   // taps read during ACCUM, so a write in the accept cycle already applies to that sample
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wr_ptr <= '0;
         base <= '0;
         k <= '0;
         acc <= '0;
         samp <= '0;
         byp <= 1'b0;
         out_hold <= '0;
         for (int i = 0; i < DEPTH; i++) line[i] <= '0;
         for (int i = 0; i < NTAPS; i++) begin
            tap_delay[i] <= ADDR_W'(def_delay(i));
            tap_coef[i] <= COEF_W'(def_coef(i));
         end
      end else begin
         if (cfg_we && cfg_ready) begin
            tap_delay[cfg_tap] <= cfg_delay;
            tap_coef[cfg_tap] <= cfg_coef;
         end
         if (accept) begin
            line[wr_ptr] <= in_data;
            base <= wr_ptr;
            wr_ptr <= wr_ptr + 1'b1;
            byp <= bypass;
            samp <= in_data;
            acc <= '0;
            k <= '0;
         end
         if (state == ACCUM) begin
            acc <= acc + ACC_W'(prod);
            k <= k + 1'b1;
         end
         if (state == OUT) out_hold <= out_val;
      end

   echo_sat_round #(.ACC_W(ACC_W), .DATA_W(DATA_W), .COEF_W(COEF_W)) u_sat (
      .acc(acc),
      .q(sat_q)
   );
endmodule

// File: tb/tb_echo_tap_generator.sv
// tb_echo_tap_generator: directed stimulus against a sample-history model of the echo generator.
module tb_echo_tap_generator;
   typedef struct {longint due; longint val;} exp_t;
   logic clk = 0, rst = 1, in_valid = 0, bypass = 0, cfg_we = 0;
   logic signed [15:0] in_data = 0, cfg_coef = 0;
   logic [1:0] cfg_tap = 0;
   logic [5:0] cfg_delay = 0;
   logic in_ready, out_valid, cfg_ready;
   logic signed [15:0] out_data;
   int vecs = 0, miss = 0;
   longint cyc = 0, idle_at = 0, m_last = 0, dut_last = 0;
   longint m_coef[4];
   int m_delay[4];
   longint hist[$];
   exp_t exp_q[$];

   echo_tap_generator dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .bypass(bypass), .out_valid(out_valid), .out_data(out_data), .cfg_we(cfg_we),
      .cfg_tap(cfg_tap), .cfg_delay(cfg_delay), .cfg_coef(cfg_coef), .cfg_ready(cfg_ready)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input longint got, input longint exp);
      vecs++;
      if (got != exp) begin
         miss++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   function automatic void model_reset();
      hist.delete();
      exp_q.delete();
      m_last = 0;
      idle_at = 0;
      m_delay = '{0, 1, 2, 0};
      m_coef = '{16384, 9830, 6553, 0};
   endfunction

   // output = Q15 weighted sum over the sample history, half-up rounded, saturated
   function automatic longint model_out(input longint x, input bit b);
      longint s = 0, r;
      int n;
      hist.push_back(x);
      n = hist.size() - 1;
      for (int t = 0; t < 4; t++)
         if (n - m_delay[t] >= 0) s += m_coef[t] * hist[n - m_delay[t]];
      r = (s + 16384) >>> 15;
      r = r > 32767 ? 32767 : r < -32768 ? -32768 : r;
      return b ? x : r;
   endfunction

   always @(negedge clk)
      if (!rst) begin
         if (out_valid) begin
            dut_last = out_data;
            if (exp_q.size() == 0) chk("spurious_out_valid", longint'(out_valid), 0);
            else begin
               chk("latency", cyc, exp_q[0].due);
               chk("out_data", out_data, exp_q[0].val);
               m_last = exp_q[0].val;
               void'(exp_q.pop_front());
            end
         end else begin
            if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
               chk("out_valid", longint'(out_valid), 1);
               void'(exp_q.pop_front());
            end
            chk("out_hold", out_data, m_last);
         end
      end

   task automatic send(input longint x, input bit b);
      int n = 0;
      while (cyc < idle_at && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("in_ready", longint'(in_ready), 1);
      in_valid = 1;
      in_data = 16'(x);
      bypass = b;
      exp_q.push_back('{due: cyc + 5, val: model_out(x, b)});
      idle_at = cyc + 6;
      @(negedge clk);
      in_valid = 0;
      bypass = 0;
      cfg_we = 0;
   endtask

   task automatic cfg_drive(input int t, input int d, input longint c);
      bit idle = cyc >= idle_at;
      cfg_we = 1;
      cfg_tap = 2'(t);
      cfg_delay = 6'(d);
      cfg_coef = 16'(c);
      chk("cfg_ready", longint'(cfg_ready), longint'(idle));
      if (idle) begin
         m_delay[t] = d;
         m_coef[t] = c;
      end
   endtask

   task automatic cfg_write(input int t, input int d, input longint c);
      cfg_drive(t, d, c);
      @(negedge clk);
      cfg_we = 0;
   endtask

   task automatic wait_out();
      int n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
   endtask

   task automatic do_reset();
      rst = 1;
      model_reset();
      @(negedge clk);
      chk("rst_out_valid", longint'(out_valid), 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_in_ready", longint'(in_ready), 1);
      chk("rst_cfg_ready", longint'(cfg_ready), 1);
      @(negedge clk);
      rst = 0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      @(negedge clk);
      do_reset();
      // impulse through default 0.5/0.3/0.2 taps
      send(1000, 0); wait_out(); chk("imp0", dut_last, 500);
      send(0, 0);    wait_out(); chk("imp1", dut_last, 300);
      send(0, 0);    wait_out(); chk("imp2", dut_last, 200);
      send(0, 0);    wait_out(); chk("imp3", dut_last, 0);
      // bypass sample still lands in the delay line
      send(-1234, 1); wait_out(); chk("bypass", dut_last, -1234);
      send(0, 0);     wait_out(); chk("after_bypass", dut_last, -370);
      // config write during ACCUM is dropped, with accept it applies
      do_reset();
      send(1000, 0);
      cfg_write(0, 0, 32767);
      wait_out(); chk("cfg_dropped", dut_last, 500);
      cfg_drive(0, 0, 32767);
      send(2000, 0); wait_out(); chk("cfg_same_cycle", dut_last, 2300);
      // reset mid-computation aborts and restores defaults
      send(777, 0);
      @(negedge clk);
      do_reset();
      repeat (10) @(negedge clk);
      chk("abort_in_ready", longint'(in_ready), 1);
      send(1000, 0); wait_out(); chk("rimp0", dut_last, 500);
      send(0, 0);    wait_out(); chk("rimp1", dut_last, 300);
      send(0, 0);    wait_out(); chk("rimp2", dut_last, 200);
      // saturation both directions
      for (int t = 0; t < 4; t++) cfg_write(t, t, 32767);
      for (int i = 0; i < 4; i++) begin send(32767, 0); wait_out(); end
      chk("sat_pos", dut_last, 32767);
      for (int i = 0; i < 4; i++) begin send(-32768, 0); wait_out(); end
      chk("sat_neg", dut_last, -32768);
      // longest delay across the write-pointer wrap
      do_reset();
      cfg_write(0, 63, 32767);
      for (int t = 1; t < 4; t++) cfg_write(t, 0, 0);
      for (int n = 0; n < 130; n++) begin
         send(n, 0);
         wait_out();
         if (n == 62 || n == 63) chk("ramp_zero", dut_last, 0);
         if (n == 64) chk("ramp64", dut_last, 1);
         if (n == 128) chk("ramp128", dut_last, 65);
         if (n == 129) chk("ramp129", dut_last, 66);
      end
      repeat (5) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
      $finish;
   end
endmodule
